// File: rtl/bimodal_predictor.sv
// bimodal_predictor: table of 2^INDEX_W two-bit saturating counters indexed by PC,
// with a registered prediction port and a separate resolve/update port.
// After reset an INIT sweep writes weak-not-taken (01) into every entry, so the
// table needs no reset and can map onto plain RAM.
// Optional build macro: BP_GSHARE_EN -- XORs a global history register into the
// request index. The port list is the same with or without it.
module bimodal_predictor #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               ready_o,
  input  logic               req_valid_i,
  input  logic [PC_W-1:0]    req_pc_i,
  output logic               rsp_valid_o,
  output logic               rsp_taken_o,
  output logic [1:0]         rsp_ctr_o,
  output logic [INDEX_W-1:0] rsp_idx_o,
  input  logic               upd_valid_i,
  input  logic [INDEX_W-1:0] upd_idx_i,
  input  logic               upd_taken_i
);

  localparam int unsigned        DEPTH    = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);
  localparam logic [1:0]         CTR_INIT = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic               ready_q;
  logic               rsp_valid_q;
  logic               rsp_taken_q;
  logic [1:0]         rsp_ctr_q;
  logic [INDEX_W-1:0] rsp_idx_q;

  logic [1:0]         table_q [DEPTH];

  logic               init_we;
  logic               upd_we;
  logic               req_acc;
  logic [INDEX_W-1:0] pc_idx;
  logic [INDEX_W-1:0] rd_idx;
  logic [1:0]         rd_ctr;
  logic [1:0]         upd_cur;
  logic [1:0]         upd_ctr;
  logic               unused_pc_bits;

  // PC bits outside the index field carry no information for the predictor
  assign unused_pc_bits = ^{req_pc_i[PC_W-1:INDEX_W+2], req_pc_i[1:0]};
  assign pc_idx         = req_pc_i[INDEX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q, ghr_d;

  // Global history shifts in each resolved direction while running
  always_comb begin
    ghr_d = ghr_q;
    if (upd_we) begin
      ghr_d = {ghr_q[INDEX_W-2:0], upd_taken_i};
    end
  end

  // Global history register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign rd_idx = pc_idx ^ ghr_q;
`else
  assign rd_idx = pc_idx;
`endif

  assign rd_ctr  = table_q[rd_idx];
  assign upd_cur = table_q[upd_idx_i];

  // Saturating +/-1 on the counter being trained
  always_comb begin
    upd_ctr = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != 2'b11) upd_ctr = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_ctr = upd_cur - 2'b01;
    end
  end

  // INIT/RUN next-state, sweep pointer and port enables; reset blocks all writes
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    upd_we  = 1'b0;
    req_acc = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + INDEX_W'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        upd_we  = upd_valid_i;
        req_acc = req_valid_i;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (rst_i) begin
      init_we = 1'b0;
      upd_we  = 1'b0;
      req_acc = 1'b0;
    end
  end

  // State register and sweep pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == ST_RUN);
    end
  end

  // Counter table: sweep writes in INIT, training writes in RUN (no reset, RAM-like)
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      table_q[ptr_q] <= CTR_INIT;
    end else if (upd_we) begin
      table_q[upd_idx_i] <= upd_ctr;
    end
  end

  // Registered prediction; fields hold their last value when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_taken_q <= 1'b0;
      rsp_ctr_q   <= 2'b00;
      rsp_idx_q   <= '0;
    end else begin
      rsp_valid_q <= req_acc;
      if (req_acc) begin
        rsp_taken_q <= rd_ctr[1];
        rsp_ctr_q   <= rd_ctr;
        rsp_idx_q   <= rd_idx;
      end
    end
  end

  assign ready_o     = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_taken_o = rsp_taken_q;
  assign rsp_ctr_o   = rsp_ctr_q;
  assign rsp_idx_o   = rsp_idx_q;

endmodule

// File: doc/bimodal_predictor.md
# bimodal_predictor

Parametrised dynamic branch predictor: a table of 2^INDEX_W two-bit saturating counters indexed by PC bits, with a registered prediction port and a separate resolve/update port. It replaces the fixed combinational two-bit predictor in the fetch-stage branch-prediction path. The front end queries it each fetch. The execute stage trains it when a branch resolves. A power-up sweep initialises the table so it maps onto plain RAM.

## Interface
- INDEX_W, 6: table index width; table depth = 2^INDEX_W entries (legal range 2..12).
- PC_W, 32: program-counter width; must satisfy PC_W >= INDEX_W + 2.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ready  out  1  high when the table is initialised and accepting traffic.
- req_valid  in  1  prediction request.
- req_pc  in  PC_W  PC of the branch being predicted.
- rsp_valid  out  1  prediction response valid.
- rsp_taken  out  1  predicted direction (1 = taken).
- rsp_ctr  out  2  counter value the prediction was based on.
- rsp_idx  out  INDEX_W  table index used; returned unchanged on the update port.
- upd_valid  in  1  branch resolved; train the table.
- upd_idx  in  INDEX_W  index from the matching rsp_idx.
- upd_taken  in  1  actual direction.

## Operation
- One clock; reset is synchronous and active-high.
- Counter encoding:
  - 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
  - Prediction = ctr[1].
- Index = req_pc[INDEX_W+1:2]. Bits [1:0] are ignored.
- State machine INIT/RUN:
  - rst forces INIT and sweep pointer = 0.
  - INIT writes 01 to entry[pointer] each cycle and increments the pointer.
  - When the pointer reaches 2^INDEX_W-1 and that entry is written, the block moves to RUN.
  - RUN persists until rst.
- During INIT:
  - ready = 0.
  - req_valid and upd_valid are ignored (no response, no table write).
- In RUN, ready = 1 and a request is accepted whenever req_valid = 1. There is no backpressure.
- Update in RUN:
  - upd_taken = 1: entry[upd_idx] saturating increment; 11 stays 11.
  - upd_taken = 0: saturating decrement; 00 stays 00.
- Simultaneous request and update to the same index: the response reflects the pre-update counter (read-before-write). The write still takes effect.
- Updates to distinct indices never disturb other entries.

## Timing
- Reset values:
  - ready = 0, rsp_valid = 0, rsp_taken = 0, rsp_ctr = 00, rsp_idx = 0.
  - Table contents are undefined until the sweep completes.
- Init latency:
  - In the first cycle after rst deasserts, entry 0 is written.
  - ready rises exactly 2^INDEX_W cycles after rst deasserts.
- Prediction latency is 1 cycle: a request accepted at edge N gives rsp_valid = 1 with rsp_* after edge N+1, for one cycle per request.
- Back-to-back requests produce back-to-back responses.
- Without a request, rsp_valid = 0 and rsp_taken/rsp_ctr/rsp_idx hold their last values.
- An update at edge N is visible to a request accepted at edge N+1.
- Reset mid-operation:
  - rsp_valid drops in the cycle after rst is sampled.
  - The sweep restarts from entry 0.
  - Any pending update is discarded.

## Configuration
- BP_GSHARE_EN defined:
  - An INDEX_W-bit global history register (GHR), reset to 0, is added.
  - Index = req_pc[INDEX_W+1:2] XOR GHR.
  - On each RUN-state upd_valid, GHR <= {GHR[INDEX_W-2:0], upd_taken}.
  - GHR is not modified during INIT.
  - rsp_idx carries the hashed index.
- BP_GSHARE_EN undefined: no GHR; pure bimodal indexing as above.
- Port list is identical in both builds.

## Test plan
- Init sweep, INDEX_W=4:
  - Release rst -> ready low for exactly 16 cycles, then high.
  - Requests to all 16 indices -> rsp_ctr = 01, rsp_taken = 0.
- Saturation up:
  - Three upd_taken = 1 updates to idx 5 -> counter 01->10->11->11.
  - Request pc = 0x14 -> rsp_taken = 1, rsp_ctr = 11, rsp_idx = 5.
- Saturation down:
  - Three upd_taken = 0 updates to idx 5 from 11 -> 10, 01, 00.
  - A further decrement keeps 00.
- Same-cycle collision:
  - req pc = 0x08 and upd idx 2 taken in the same cycle -> response rsp_ctr = 01.
  - Next request to pc = 0x08 -> rsp_ctr = 10.
- Reset mid-run:
  - Assert rst one cycle while rsp_valid = 1 -> rsp_valid = 0 next cycle, ready low for 16 cycles.
  - All counters read back 01 afterwards.
- BP_GSHARE_EN build:
  - Updates taken, taken, not-taken -> GHR = 0110.
  - Request pc = 0x04 -> rsp_idx = 0001 XOR 0110 = 0111.
